// File: rtl/sfr_read_ctrl.sv
// -----------------------------------------------------------------------------
// sfr_read_ctrl
// Read controller for the special-function-register space. A read request
// in IDLE latches the address and mode. In CAPTURE the controller selects
// the source byte, or one bit of it, from the SFR source buses. The result
// is registered and presented with a one-cycle rd_valid pulse in RESP.
//
// Optional feature, macro SFR_RD_FWD_EN:
//   When this macro is defined, a write on the snoop bus in the CAPTURE
//   cycle to the same target byte is forwarded into the read result. This
//   covers both byte writes and bit writes. When the macro is undefined,
//   the snoop inputs are ignored.
//
// Ports:
//   clock, reset          system clock; asynchronous active-high reset
//   rd_en, rd_bit_en      read request (sampled in IDLE); 1 = bit read
//   addr                  SFR byte address or bit address
//   *_data                SFR source bytes (ACC, B, PSW, SP, DPL, DPH,
//                         P0-P3, IE, IP)
//   wr_en, wr_bit_en,     write-bus snoop (used only with SFR_RD_FWD_EN)
//   wr_addr, wr_data,
//   bit_in
//   data_out, bit_out     registered read results, held until next read
//   rd_valid              one-cycle pulse in RESP
//   busy                  high in CAPTURE and RESP
//   undef_addr            unmapped access flag, valid with rd_valid
//
// State table:
//   state   | meaning
//   IDLE    | waiting for rd_en; latches addr/mode on request
//   CAPTURE | selects the source and registers the result
//   RESP    | result valid, rd_valid high
// -----------------------------------------------------------------------------
module sfr_read_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       rd_en,
    input  logic       rd_bit_en,
    input  logic [7:0] addr,
    input  logic [7:0] acc_data,
    input  logic [7:0] b_data,
    input  logic [7:0] psw_data,
    input  logic [7:0] sp_data,
    input  logic [7:0] dpl_data,
    input  logic [7:0] dph_data,
    input  logic [7:0] p0_data,
    input  logic [7:0] p1_data,
    input  logic [7:0] p2_data,
    input  logic [7:0] p3_data,
    input  logic [7:0] ie_data,
    input  logic [7:0] ip_data,
    input  logic       wr_en,
    input  logic       wr_bit_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       bit_in,
    output logic [7:0] data_out,
    output logic       bit_out,
    output logic       rd_valid,
    output logic       busy,
    output logic       undef_addr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic       bit_mode_q, bit_mode_d;
    logic [7:0] data_out_q, data_out_d;
    logic       bit_out_q, bit_out_d;
    logic       rd_valid_q, rd_valid_d;
    logic       undef_q, undef_d;

    logic [7:0] target;
    logic [2:0] bit_idx;
    logic [7:0] src_byte;
    logic       src_hit;
    logic       bit_base;
    logic [7:0] fwd_byte;

    // A bit address names its containing byte by clearing the low three bits.
    assign target  = bit_mode_q ? {addr_q[7:3], 3'b000} : addr_q;
    assign bit_idx = addr_q[2:0];

    // Source decode. bit_base marks the bytes that are bit-addressable.
    // All of them are also byte-mapped.
    always_comb begin
        src_byte = 8'h00;
        src_hit  = 1'b0;
        bit_base = 1'b0;
        case (target)
            8'hE0: begin src_byte = acc_data; src_hit = 1'b1; bit_base = 1'b1; end
            8'hF0: begin src_byte = b_data;   src_hit = 1'b1; bit_base = 1'b1; end
            8'hD0: begin src_byte = psw_data; src_hit = 1'b1; bit_base = 1'b1; end
            8'h81: begin src_byte = sp_data;  src_hit = 1'b1; end
            8'h82: begin src_byte = dpl_data; src_hit = 1'b1; end
            8'h83: begin src_byte = dph_data; src_hit = 1'b1; end
            8'h80: begin src_byte = p0_data;  src_hit = 1'b1; bit_base = 1'b1; end
            8'h90: begin src_byte = p1_data;  src_hit = 1'b1; bit_base = 1'b1; end
            8'hA0: begin src_byte = p2_data;  src_hit = 1'b1; bit_base = 1'b1; end
            8'hB0: begin src_byte = p3_data;  src_hit = 1'b1; bit_base = 1'b1; end
            8'hA8: begin src_byte = ie_data;  src_hit = 1'b1; bit_base = 1'b1; end
            8'hB8: begin src_byte = ip_data;  src_hit = 1'b1; bit_base = 1'b1; end
            default: begin
                src_byte = 8'h00;
                src_hit  = 1'b0;
                bit_base = 1'b0;
            end
        endcase
    end

`ifdef SFR_RD_FWD_EN
    // A write landing in the same cycle as the capture takes priority
    // over the stale source value. This keeps read-after-write coherent.
    always_comb begin
        fwd_byte = src_byte;
        if (wr_en && !wr_bit_en && (wr_addr == target)) begin
            fwd_byte = wr_data;
        end else if (wr_en && wr_bit_en && ({wr_addr[7:3], 3'b000} == target)) begin
            fwd_byte[wr_addr[2:0]] = bit_in;
        end
    end
`else
    logic unused_snoop;
    assign unused_snoop = ^{wr_en, wr_bit_en, wr_addr, wr_data, bit_in};
    assign fwd_byte     = src_byte;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        bit_mode_d = bit_mode_q;
        data_out_d = data_out_q;
        bit_out_d  = bit_out_q;
        rd_valid_d = 1'b0;
        undef_d    = undef_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_en) begin
                    addr_d     = addr;
                    bit_mode_d = rd_bit_en;
                    state_d    = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d    = ST_RESP;
                rd_valid_d = 1'b1;
                if (bit_mode_q) begin
                    bit_out_d = bit_base ? fwd_byte[bit_idx] : 1'b0;
                    undef_d   = !bit_base;
                end else begin
                    data_out_d = src_hit ? fwd_byte : 8'h00;
                    undef_d    = !src_hit;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= 8'h00;
            bit_mode_q <= 1'b0;
            data_out_q <= 8'h00;
            bit_out_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            undef_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            bit_mode_q <= bit_mode_d;
            data_out_q <= data_out_d;
            bit_out_q  <= bit_out_d;
            rd_valid_q <= rd_valid_d;
            undef_q    <= undef_d;
        end
    end

    assign data_out   = data_out_q;
    assign bit_out    = bit_out_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign undef_addr = undef_q;

endmodule

// File: doc/sfr_read_ctrl.md
SFR_READ_CTRL -- requirements
Module: sfr_read_ctrl

Interface
REQ-001 SHALL have: clock  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: rd_en  input  1  read request, sampled in IDLE only.
REQ-004 SHALL have: rd_bit_en  input  1  1 = bit read, 0 = byte read.
REQ-005 SHALL have: addr  input  8  SFR byte address or bit address.
REQ-006 SHALL have byte sources, each input 8: acc_data E0h, b_data F0h, psw_data D0h, sp_data 81h, dpl_data 82h, dph_data 83h, p0_data 80h, p1_data 90h, p2_data A0h, p3_data B0h, ie_data A8h, ip_data B8h.
REQ-007 SHALL have write-bus snoop inputs (used only under SFR_RD_FWD_EN): wr_en 1, wr_bit_en 1, wr_addr 8, wr_data 8, bit_in 1.
REQ-008 SHALL have: data_out  output  8  registered byte read result.
REQ-009 SHALL have: bit_out  output  1  registered bit read result.
REQ-010 SHALL have: rd_valid  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have: busy  output  1  high in CAPTURE and RESP.
REQ-012 SHALL have: undef_addr  output  1  registered, valid with rd_valid; unmapped access.

Function
REQ-013 FSM SHALL have states IDLE, CAPTURE, RESP; IDLE->CAPTURE on rd_en, CAPTURE->RESP always, RESP->IDLE always.
REQ-014 In IDLE with rd_en=1, addr and rd_bit_en SHALL be latched; rd_valid SHALL pulse exactly 2 cycles after the rd_en edge.
REQ-015 rd_en while busy=1 SHALL be ignored (no queueing, no error).
REQ-016 Byte read: target = addr; bit read: target = {addr[7:3],3'b000}, bit index = addr[2:0].
REQ-017 Source selection SHALL occur in CAPTURE, using source values present in that cycle; result registered at CAPTURE->RESP edge.
REQ-018 Byte read of mapped address: data_out = source byte; bit_out unchanged.
REQ-019 Bit read: bit_out = source[index]; data_out unchanged; legal only for 80h,90h,A0h,A8h,B0h,B8h,D0h,E0h,F0h bases.
REQ-020 Bit addresses 00h-7Fh (internal RAM bit space) and bases not in REQ-019 SHALL give bit_out=0, undef_addr=1.
REQ-021 Byte address not in REQ-006 SHALL give data_out=00h, undef_addr=1; mapped accesses give undef_addr=0.
REQ-022 data_out, bit_out SHALL hold last result until next completed read; undef_addr updates every RESP.
REQ-023 rd_valid SHALL be high only in RESP; busy = (state != IDLE).

Reset
REQ-024 Reset SHALL force state IDLE, data_out=00h, bit_out=0, rd_valid=0, busy=0, undef_addr=0, latched addr/mode cleared.
REQ-025 Reset asserted in CAPTURE or RESP SHALL abort the read; no rd_valid pulse after deassertion.
REQ-026 First rd_en SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro SFR_RD_FWD_EN defined: in CAPTURE, a coincident write to the same target SHALL be forwarded -- byte write (wr_en & !wr_bit_en, wr_addr==target) supplies wr_data; bit write (wr_en & wr_bit_en, {wr_addr[7:3],000}==target) replaces bit wr_addr[2:0] with bit_in before selection.
REQ-028 Macro undefined: snoop inputs SHALL be ignored; result always from source inputs.

Verification
REQ-029 Reset, rd_en=1 addr=F0h byte, b_data=5Ah -> rd_valid 2 cycles later, data_out=5Ah, undef_addr=0.
REQ-030 Bit read addr=D7h, psw_data=80h -> bit_out=1, data_out unchanged; addr=D6h -> bit_out=0.
REQ-031 Byte read 99h and bit read 0Fh -> data_out=00h / bit_out=0, undef_addr=1 each.
REQ-032 rd_en held high 4 cycles from IDLE -> one rd_valid only, next read accepted after RESP.
REQ-033 Reset pulse during CAPTURE -> no rd_valid, data_out=00h, busy=0.
REQ-034 FWD_EN: read E0h, acc_data=11h, same-cycle byte write E0h wr_data=22h -> data_out=22h; without macro -> 11h.
